// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - opcode map, FSM states and control bundle for the multicycle sequencer
package uc_pkg;

  localparam logic [5:0] OP_J         = 6'b000100;
  localparam logic [5:0] OP_JZ        = 6'b000010;
  localparam logic [5:0] OP_JNZ       = 6'b000001;
  localparam logic [5:0] OP_HALT      = 6'b000011;
  localparam logic [3:0] OP_LI_PREFIX = 4'b0100;
  localparam int         ALU_BIT      = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT,
    ERR
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op_alu;
  } ctrl_t;

  // Safe bundle: no writes, PC mux parked on increment
  localparam ctrl_t CTRL_DEFAULT = '{pc_en: 1'b0, s_inc: 1'b1, s_inm: 1'b0,
                                     we3: 1'b0, wez: 1'b0, op_alu: 3'b000};

  function automatic logic branch_taken(input logic [5:0] opcode, input logic z);
    return (opcode == OP_J) | ((opcode == OP_JZ) & z) | ((opcode == OP_JNZ) & ~z);
  endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// rtl/uc_multiciclo_if.sv - instruction-memory handshake and datapath control bus
interface uc_multiciclo_if;
  logic       imem_req;
  logic       imem_ack;
  logic       ir_load;
  logic       pc_en;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op_alu;
  logic [5:0] opcode;
  logic       z;

  modport master (
    output imem_req, ir_load, pc_en, s_inc, s_inm, we3, wez, op_alu,
    input  imem_ack, opcode, z
  );

  modport slave (
    input  imem_req, ir_load, pc_en, s_inc, s_inm, we3, wez, op_alu,
    output imem_ack, opcode, z
  );
endinterface

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - maps opcode and latched branch decision to the EXEC control bundle
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       taken,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_DEFAULT;
    if (opcode != OP_HALT) begin
      ctrl.pc_en = 1'b1;
      ctrl.s_inc = ~taken;
      if (opcode[ALU_BIT]) begin
        ctrl.we3    = 1'b1;
        ctrl.wez    = 1'b1;
        ctrl.op_alu = opcode[4:2];
      end else if (opcode[5:2] == OP_LI_PREFIX) begin
        ctrl.we3   = 1'b1;
        ctrl.s_inm = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - FETCH/DECODE/EXEC sequencer with run/halt, fetch timeout and retire count
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  uc_multiciclo_if.master      bus,
  output logic                 halted,
  output logic                 err,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  ctrl_t dec_ctrl;
  ctrl_t ctrl;
  logic  imem_req;
  logic  ir_load;

  uc_decode u_decode (
    .opcode (bus.opcode),
    .taken  (taken_q),
    .ctrl   (dec_ctrl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      taken_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      taken_q   <= taken_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    taken_d   = taken_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    halted    = 1'b0;
    err       = 1'b0;
    ctrl      = CTRL_DEFAULT;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // An ack in the cycle the count would expire still completes the fetch
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          tmo_d   = '0;
          state_d = DECODE;
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_d == TMO_MAX) state_d = ERR;
        end
      end
      DECODE: begin
        taken_d = branch_taken(bus.opcode, bus.z);
        state_d = EXEC;
      end
      EXEC: begin
        ctrl = dec_ctrl;
        if (bus.opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          retired_d = retired_q + 1'b1;
          state_d   = run ? FETCH : IDLE;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (!run) state_d = IDLE;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_load  = ir_load;
  assign bus.pc_en    = ctrl.pc_en;
  assign bus.s_inc    = ctrl.s_inc;
  assign bus.s_inm    = ctrl.s_inm;
  assign bus.we3      = ctrl.we3;
  assign bus.wez      = ctrl.wez;
  assign bus.op_alu   = ctrl.op_alu;
  assign retired      = retired_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - scoreboard bench for the multicycle sequencer
module tb_uc_multiciclo;
  import uc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        halted;
  logic        err;
  logic [15:0] retired;

  uc_multiciclo_if bus();

  uc_multiciclo #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .bus     (bus),
    .halted  (halted),
    .err     (err),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_ret = 0;
  int    lat;
  int    cnt;
  ctrl_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t mk(input logic p, input logic i, input logic m,
                               input logic w, input logic zf, input logic [2:0] o);
    ctrl_t c;
    c.pc_en = p; c.s_inc = i; c.s_inm = m; c.we3 = w; c.wez = zf; c.op_alu = o;
    return c;
  endfunction

  task automatic check_ctrl(input string tag, input ctrl_t e);
    check({tag, ".pc_en"},  bus.pc_en,  e.pc_en);
    check({tag, ".s_inc"},  bus.s_inc,  e.s_inc);
    check({tag, ".s_inm"},  bus.s_inm,  e.s_inm);
    check({tag, ".we3"},    bus.we3,    e.we3);
    check({tag, ".wez"},    bus.wez,    e.wez);
    check({tag, ".op_alu"}, bus.op_alu, e.op_alu);
  endtask

  // One instruction: optional stalls, ack, DECODE, EXEC (compared against the scoreboard)
  task automatic run_instr(input string tag, input logic [5:0] op, input logic zv,
                           input int stalls, input bit flip_z, input bit drop_run,
                           input bit rst_exec, output int cycles);
    cycles = 0;
    for (int i = 0; i < 20 && !bus.imem_req; i++) begin
      @(negedge clk); #1;
    end
    if (!bus.imem_req) begin
      check({tag, ".fetch_wait"}, 0, 1);
      return;
    end
    for (int s = 0; s < stalls; s++) begin
      check({tag, ".stall_ir_load"}, bus.ir_load, 0);
      cycles++;
      @(negedge clk); #1;
    end
    bus.imem_ack = 1'b1;
    bus.opcode   = op;
    bus.z        = zv;
    #1;
    check({tag, ".ir_load"}, bus.ir_load, 1);
    cycles++;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    if (drop_run) run = 1'b0;
    #1;
    check({tag, ".decode_req"}, bus.imem_req, 0);
    cycles++;
    @(negedge clk);
    if (flip_z) bus.z = ~zv;
    #1;
    cycles++;
    if (exp_q.size() == 0) check({tag, ".sb_empty"}, 1, 0);
    else check_ctrl({tag, ".exec"}, exp_q.pop_front());
    if (rst_exec) begin
      reset = 1'b0;
      #1;
      check({tag, ".rst_we3"},   bus.we3,   0);
      check({tag, ".rst_pc_en"}, bus.pc_en, 0);
      check({tag, ".rst_wez"},   bus.wez,   0);
      @(negedge clk);
      reset   = 1'b1;
      exp_ret = 0;
      #1;
      check({tag, ".rst_retired"}, retired, 0);
      return;
    end
    @(negedge clk); #1;
    check({tag, ".retired"}, retired, exp_ret);
    if (drop_run) begin
      check({tag, ".idle_req"}, bus.imem_req, 0);
      @(negedge clk); #1;
      check({tag, ".idle_req2"}, bus.imem_req, 0);
      run = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    run          = 1'b1;
    bus.opcode   = 6'b100100;
    bus.z        = 1'b0;
    bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.imem_req", bus.imem_req, 0);
    check("rst.ir_load",  bus.ir_load,  0);
    check_ctrl("rst", mk(0, 1, 0, 0, 0, 3'b000));
    check("rst.halted",   halted,  0);
    check("rst.err",      err,     0);
    check("rst.retired",  retired, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle.imem_req", bus.imem_req, 0);
    @(negedge clk); #1;
    check("fetch.imem_req", bus.imem_req, 1);

    exp_ret = 1; exp_q.push_back(mk(1, 1, 0, 1, 1, 3'b010));
    run_instr("alu", 6'b101000, 0, 0, 0, 0, 0, lat);
    check("alu.latency", lat, 3);

    exp_ret = 2; exp_q.push_back(mk(1, 0, 0, 0, 0, 3'b000));
    run_instr("jz_z1", 6'b000010, 1, 0, 1, 0, 0, lat);
    exp_ret = 3; exp_q.push_back(mk(1, 1, 0, 0, 0, 3'b000));
    run_instr("jnz_z1", 6'b000001, 1, 0, 1, 0, 0, lat);
    exp_ret = 4; exp_q.push_back(mk(1, 0, 0, 0, 0, 3'b000));
    run_instr("jnz_z0", 6'b000001, 0, 0, 1, 0, 0, lat);
    exp_ret = 5; exp_q.push_back(mk(1, 1, 0, 0, 0, 3'b000));
    run_instr("jz_z0", 6'b000010, 0, 0, 0, 0, 0, lat);
    exp_ret = 6; exp_q.push_back(mk(1, 0, 0, 0, 0, 3'b000));
    run_instr("jmp", 6'b000100, 0, 0, 0, 0, 0, lat);
    exp_ret = 7; exp_q.push_back(mk(1, 1, 1, 1, 0, 3'b000));
    run_instr("li", 6'b010010, 1, 0, 0, 0, 0, lat);
    exp_ret = 8; exp_q.push_back(mk(1, 1, 0, 0, 0, 3'b000));
    run_instr("nop", 6'b001000, 1, 0, 0, 0, 0, lat);
    exp_ret = 9; exp_q.push_back(mk(1, 1, 0, 1, 1, 3'b111));
    run_instr("alu7", 6'b111111, 0, 0, 0, 0, 0, lat);

    exp_ret = 10; exp_q.push_back(mk(1, 1, 0, 1, 1, 3'b000));
    run_instr("stall3", 6'b100000, 0, 3, 0, 0, 0, lat);
    check("stall3.latency", lat, 6);
    exp_ret = 11; exp_q.push_back(mk(1, 1, 1, 1, 0, 3'b000));
    run_instr("stall14", 6'b010001, 0, 14, 0, 0, 0, lat);
    check("stall14.latency", lat, 17);
    check("stall14.err", err, 0);

    exp_ret = 12; exp_q.push_back(mk(1, 1, 0, 1, 1, 3'b101));
    run_instr("rundrop", 6'b110100, 0, 0, 0, 1, 0, lat);

    exp_q.push_back(mk(0, 1, 0, 0, 0, 3'b000));
    run_instr("halt", OP_HALT, 0, 0, 0, 0, 0, lat);
    check("halt.halted", halted, 1);
    @(negedge clk); #1;
    check("halt.hold", halted, 1);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk); #1;
    check("halt.exit", halted, 0);
    check("halt.idle_req", bus.imem_req, 0);
    run = 1'b1;
    @(negedge clk); #1;
    check("halt.resume_req", bus.imem_req, 1);

    exp_ret = 13; exp_q.push_back(mk(1, 1, 0, 1, 1, 3'b001));
    run_instr("rst_exec", 6'b100100, 0, 0, 0, 0, 1, lat);

    cnt = 0;
    for (int i = 0; i < 40 && !err; i++) begin
      if (bus.imem_req) cnt++;
      @(negedge clk); #1;
    end
    check("tmo.err", err, 1);
    check("tmo.fetch_cycles", cnt, 15);
    repeat (5) @(negedge clk);
    #1;
    check("tmo.err_sticky", err, 1);
    check("tmo.no_req", bus.imem_req, 0);
    reset = 1'b0;
    #1;
    check("tmo.err_clear", err, 0);
    check("tmo.retired", retired, 0);
    @(negedge clk);
    reset = 1'b1;
    check("sb.drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
